// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot decoder family: FSM state,
// mode encodings and a width-generic one-hot builder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned ONEHOT_MAX   = 256;
  localparam int unsigned ONEHOT_IDX_W = 16;

  // Callers size the result down to their own output width; indices at or
  // beyond 'width' yield an all-zero word.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [ONEHOT_IDX_W-1:0] idx,
                                                   input int unsigned width);
    logic [ONEHOT_MAX-1:0] r;
    r = '0;
    if (({16'd0, idx} < width) && (idx[15:8] == 8'd0)) begin
      r[idx[7:0]] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell tick generator: tick is high on the last cycle of each DWELL-cycle
// period; clear restarts the period.
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with an on-demand DECODE mode and an
// autonomous SCAN mode that walks the active bit with a programmable dwell.
module onehot_decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_WIDTH = 3,
  parameter int OUT_WIDTH = 8,
  parameter int DWELL     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 valid_in,
  input  logic [SEL_WIDTH-1:0] data_in,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic [SEL_WIDTH-1:0] index_out,
  output logic                 valid_out,
  output logic                 err_out,
  output logic                 wrap_pulse
);

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(OUT_WIDTH - 1);
  localparam logic [SEL_WIDTH-1:0] IDX_ONE  = SEL_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   data_q, data_d;
  logic [SEL_WIDTH-1:0]   idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   wrap_q, wrap_d;
  logic                   cnt_clr;
  logic                   tick;
  logic                   in_range;

  assign in_range = (data_in <= LAST_IDX);

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    err_d   = err_q;
    wrap_d  = 1'b0;
    cnt_clr = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      data_d  = '0;
    end else if (mode == MODE_DECODE) begin
      state_d = DECODE;
      if (valid_in) begin
        idx_d   = data_in;
        valid_d = 1'b1;
        err_d   = !in_range;
        data_d  = OUT_WIDTH'(onehot(ONEHOT_IDX_W'(data_in), OUT_WIDTH));
      end
    end else begin
      state_d = SCAN;
      valid_d = 1'b1;
      // Entry beats reload, reload beats the dwell advance.
      if (state_q != SCAN) begin
        idx_d = '0;
        err_d = 1'b0;
      end else if (valid_in) begin
        cnt_clr = 1'b1;
        if (in_range) begin
          idx_d = data_in;
          err_d = 1'b0;
        end else begin
          idx_d = '0;
          err_d = 1'b1;
        end
      end else if (tick) begin
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          wrap_d = 1'b1;
          err_d  = 1'b0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      data_d = OUT_WIDTH'(onehot(ONEHOT_IDX_W'(idx_d), OUT_WIDTH));
    end

    if ((state_d != state_q) || (state_d != SCAN)) begin
      cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
    end
  end

  assign data_out   = data_q;
  assign index_out  = idx_q;
  assign valid_out  = valid_q;
  assign err_out    = err_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Vector/scoreboard bench for onehot_decoder_seq (SEL_WIDTH=3, OUT_WIDTH=6, DWELL=2).
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic       valid_in = 1'b0;
  logic [2:0] data_in = 3'd0;
  logic [5:0] data_out;
  logic [2:0] index_out;
  logic       valid_out;
  logic       err_out;
  logic       wrap_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic       rst, en, md, vin;
    logic [2:0] din;
    logic [5:0] data;
    logic [2:0] idx;
    logic       vld, err, wrap;
    string      name;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  onehot_decoder_seq #(
    .SEL_WIDTH (3),
    .OUT_WIDTH (6),
    .DWELL     (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .index_out  (index_out),
    .valid_out  (valid_out),
    .err_out    (err_out),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic rst, input logic en, input logic md, input logic vin,
                              input logic [2:0] din, input logic [5:0] data, input logic [2:0] idx,
                              input logic vld, input logic err, input logic wrap, input string nm);
    vec_t v;
    v.rst = rst; v.en = en; v.md = md; v.vin = vin; v.din = din;
    v.data = data; v.idx = idx; v.vld = vld; v.err = err; v.wrap = wrap; v.name = nm;
    vecs.push_back(v);
  endfunction

  initial begin
    vec_t e;
    int   ix;
    int   waited;
    bit   seen_wrap;

    // Reset held with SCAN requested, then release into SCAN
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0, "reset");
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 6'b000001, 3'd0, 1'b1, 1'b0, 1'b0, "scan_entry");
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 6'b000001, 3'd0, 1'b1, 1'b0, 1'b0, "scan_hold");
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 6'b000001, 3'd0, 1'b0, 1'b0, 1'b0, "to_decode");
    // DECODE sweep, back-to-back requests
    for (int n = 0; n < 6; n++)
      add(1'b0, 1'b1, 1'b0, 1'b1, 3'(n), 6'(1 << n), 3'(n), 1'b1, 1'b0, 1'b0, "dec_sweep");
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 6'b100000, 3'd5, 1'b0, 1'b0, 1'b0, "dec_hold");
    add(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 6'b000000, 3'd6, 1'b1, 1'b1, 1'b0, "dec_oor6");
    add(1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 6'b000000, 3'd7, 1'b1, 1'b1, 1'b0, "dec_oor7");
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 6'b000000, 3'd7, 1'b0, 1'b1, 1'b0, "dec_oor_hold");
    add(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 6'b000100, 3'd2, 1'b1, 1'b0, 1'b0, "dec_recover");
    // SCAN walk: each index held two cycles, wrap pulse when bit 0 returns
    for (int k = 0; k < 14; k++) begin
      ix = (k / 2) % 6;
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 6'(1 << ix), 3'(ix), 1'b1, 1'b0, (k == 12), "scan_walk");
    end
    // Reload on the advance cycle wins, then a full dwell at index 4
    add(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 6'b010000, 3'd4, 1'b1, 1'b0, 1'b0, "reload_collide");
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 6'b010000, 3'd4, 1'b1, 1'b0, 1'b0, "reload_hold");
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 6'b100000, 3'd5, 1'b1, 1'b0, 1'b0, "after_reload");
    add(1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 6'b000001, 3'd0, 1'b1, 1'b1, 1'b0, "reload_oor");
    for (int m = 1; m <= 18; m++) begin
      ix = (m / 2) % 6;
      add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 6'(1 << ix), 3'(ix), 1'b1, (m < 12), (m == 12), "scan_err_clear");
    end
    // Disable at index 3, re-enable, then synchronous reset mid-scan
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 6'b000000, 3'd3, 1'b0, 1'b0, 1'b0, "disable");
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 6'b000000, 3'd3, 1'b0, 1'b0, 1'b0, "idle_hold");
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 6'b000001, 3'd0, 1'b1, 1'b0, 1'b0, "reenable");
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 6'b000001, 3'd0, 1'b1, 1'b0, 1'b0, "reenable_hold");
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 6'b000010, 3'd1, 1'b1, 1'b0, 1'b0, "reenable_adv");
    add(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0, "reset_mid_scan");
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0, "post_reset_idle");

    for (int i = 0; i < vecs.size(); i++) begin
      reset    = vecs[i].rst;
      enable   = vecs[i].en;
      mode     = vecs[i].md;
      valid_in = vecs[i].vin;
      data_in  = vecs[i].din;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      tests_run++;
      if ({data_out, index_out, valid_out, err_out, wrap_pulse} !==
          {e.data, e.idx, e.vld, e.err, e.wrap}) begin
        tests_failed++;
        $display("FAIL %s step %0d: got data=%b idx=%0d vld=%b err=%b wrap=%b, want data=%b idx=%0d vld=%b err=%b wrap=%b",
                 e.name, i, data_out, index_out, valid_out, err_out, wrap_pulse,
                 e.data, e.idx, e.vld, e.err, e.wrap);
      end
    end

    reset    = 1'b1;
    enable   = 1'b1;
    mode     = 1'b1;
    valid_in = 1'b0;
    data_in  = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({data_out, index_out, valid_out, err_out, wrap_pulse} !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got data=%b idx=%0d vld=%b err=%b wrap=%b, want all zero",
               data_out, index_out, valid_out, err_out, wrap_pulse);
    end

    reset     = 1'b0;
    seen_wrap = 1'b0;
    for (waited = 0; (waited < 30) && !seen_wrap; waited++) begin
      @(posedge clk);
      #1;
      if (wrap_pulse === 1'b1) seen_wrap = 1'b1;
    end
    tests_run++;
    if (!seen_wrap) begin
      tests_failed++;
      $display("FAIL wrap_wait: no wrap_pulse within %0d cycles of scan start", waited);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
Parametrised, registered successor to the 3-to-8 combinational decoder. It converts a SEL_WIDTH-bit index into an OUT_WIDTH-bit one-hot word.
- DECODE mode: decodes on demand, one index per valid_in strobe.
- SCAN mode: autonomously walks the active bit across all outputs with a programmable dwell and a wrap indication.
- Intended to drive chip-selects, LED/row strobes and bank enables in the same datapath area as the existing decoder.

Parameters:
SEL_WIDTH, 3, width of index input/output
OUT_WIDTH, 8, number of one-hot outputs; legal range 2..2**SEL_WIDTH
DWELL, 4, clock cycles each output stays active in SCAN mode; legal range 1..65535

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
enable  input  1  block enable; low forces idle
mode  input  1  0 = DECODE, 1 = SCAN
valid_in  input  1  data_in qualifier (decode request, or scan reload)
data_in  input  SEL_WIDTH  index to decode/load
data_out  output  OUT_WIDTH  registered one-hot word
index_out  output  SEL_WIDTH  index currently driven on data_out
valid_out  output  1  data_out updated this cycle
err_out  output  1  last accepted index was out of range (>= OUT_WIDTH)
wrap_pulse  output  1  one-cycle pulse when SCAN wraps from OUT_WIDTH-1 to 0

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, sampled on the rising edge of clk. All outputs are registered.
- Reset values: data_out = 0, index_out = 0, valid_out = 0, err_out = 0, wrap_pulse = 0. Dwell counter = 0; state = IDLE.
- Reset has priority over every other input and aborts any scan in progress.
- States: IDLE, DECODE, SCAN.
- IDLE:
  - enable=0 forces IDLE next cycle.
  - On entering IDLE: data_out <= 0, valid_out <= 0, wrap_pulse <= 0. index_out and err_out hold.
  - From IDLE with enable=1: go to DECODE if mode=0, SCAN if mode=1.
- Mode-change transitions:
  - Same-cycle transition DECODE<->SCAN when mode changes.
  - Dwell counter clears on every state change.
- DECODE (latency 1 cycle):
  - valid_in=1 with data_in < OUT_WIDTH: data_out <= 1<<data_in, index_out <= data_in, err_out <= 0, valid_out <= 1.
  - valid_in=1 with data_in >= OUT_WIDTH: data_out <= 0, index_out <= data_in, err_out <= 1, valid_out <= 1.
  - valid_in=0: data_out, index_out and err_out hold; valid_out <= 0. valid_out is a per-request pulse.
  - Back-to-back valid_in is accepted every cycle; no backpressure.
- SCAN:
  - Entry cycle: index_out <= 0, data_out <= 1, valid_out <= 1, err_out <= 0, counter <= 0.
  - valid_out stays 1 for every cycle in SCAN.
  - Dwell counter increments each cycle. When counter == DWELL-1: counter <= 0 and index advances by 1.
  - Wrap: index OUT_WIDTH-1 advances to 0, and wrap_pulse <= 1 in the same registered cycle that data_out returns to bit 0. wrap_pulse is otherwise 0.
  - DWELL=1: index advances every cycle.
  - Reload: valid_in=1 in SCAN sets index <= data_in and counter <= 0. Reload has priority over the advance in the same cycle.
  - Out-of-range reload: index <= 0 and err_out <= 1. err_out clears on the next wrap.
  - Reload never asserts wrap_pulse.
- enable falling mid-scan: next cycle is IDLE per the rules above. Re-enable restarts SCAN at index 0.
- Width rules:
  - Dwell counter width is $clog2(DWELL)+1.
  - The one-hot shift is computed at OUT_WIDTH bits; no truncation warnings are allowed.
  - Index compare is at SEL_WIDTH bits.

Decomposition:
- Shared package decoder_pkg holds:
  - state typedef (IDLE, DECODE, SCAN);
  - MODE_DECODE / MODE_SCAN constants;
  - function onehot(idx, width), returning 0 for out-of-range idx. Reused by the legacy decoder rewrite.
- One sub-module, dwell_counter, holds the parametrised DWELL tick generator with clear input and tick output. The FSM, index register and output registers stay in the top level.

Test Plan (SEL_WIDTH=3, OUT_WIDTH=6, DWELL=2 unless noted):
- Reset: hold reset 3 cycles with enable=1, mode=1 -> all outputs 0. Then release -> data_out=000001 one cycle after entering SCAN.
- DECODE sweep: mode=0, valid_in pulses with data_in=0..5 -> data_out=1<<n one cycle later, valid_out pulses, err_out=0.
- DECODE out-of-range: data_in=6, then 7 -> data_out=0, err_out=1, index_out=6/7. Then data_in=2 -> data_out=000100, err_out=0.
- SCAN walk/wrap: mode=1 for 14 cycles -> each bit held 2 cycles, 0..5. wrap_pulse=1 exactly when data_out returns to 000001; valid_out constant 1.
- SCAN reload plus collision: valid_in with data_in=4 on the cycle the counter would advance -> index_out=4 held 2 cycles, no wrap_pulse. Then reload data_in=7 -> index 0, err_out=1, cleared at next wrap.
- Disable/reset mid-scan: enable=0 at index 3 -> data_out=0, valid_out=0, index_out=3 held. Re-enable -> restart at 000001. Synchronous reset mid-scan -> all outputs 0 next edge.
